// File: rtl/rgb2ycbcr_pkg.sv
// Shared constants and FSM state type for the RGB to YCbCr block converter.
// Coefficients are BT.601 full-range weights scaled by 2^FRAC_BITS.
package rgb2ycbcr_pkg;

  localparam int FRAC_BITS = 16;

  localparam int C_Y_R  = 19595;
  localparam int C_Y_G  = 38470;
  localparam int C_Y_B  = 7471;

  localparam int C_CB_R = -11059;
  localparam int C_CB_G = -21710;
  localparam int C_CB_B = 32768;

  localparam int C_CR_R = 32768;
  localparam int C_CR_G = -27439;
  localparam int C_CR_B = -5329;

  localparam int C_OFF  = 32'h0080_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/rgb2ycbcr_core.sv
// One-pixel combinational RGB to YCbCr converter, signed Q16.16 outputs.
// Arithmetic runs at the output width, which must be at least 26 bits.
module rgb2ycbcr_core
  import rgb2ycbcr_pkg::*;
#(
  parameter int fixed_point_length = 32,
  parameter int input_width        = 8
) (
  input  logic        [input_width-1:0]        r,
  input  logic        [input_width-1:0]        g,
  input  logic        [input_width-1:0]        b,
  output logic signed [fixed_point_length-1:0] y,
  output logic signed [fixed_point_length-1:0] cb,
  output logic signed [fixed_point_length-1:0] cr
);

  localparam int W = fixed_point_length;

  localparam logic signed [W-1:0] KYR  = W'(C_Y_R);
  localparam logic signed [W-1:0] KYG  = W'(C_Y_G);
  localparam logic signed [W-1:0] KYB  = W'(C_Y_B);
  localparam logic signed [W-1:0] KCBR = W'(C_CB_R);
  localparam logic signed [W-1:0] KCBG = W'(C_CB_G);
  localparam logic signed [W-1:0] KCBB = W'(C_CB_B);
  localparam logic signed [W-1:0] KCRR = W'(C_CR_R);
  localparam logic signed [W-1:0] KCRG = W'(C_CR_G);
  localparam logic signed [W-1:0] KCRB = W'(C_CR_B);
  localparam logic signed [W-1:0] KOFF = W'(C_OFF);

  logic signed [W-1:0] rs;
  logic signed [W-1:0] gs;
  logic signed [W-1:0] bs;

  // Samples are unsigned, so widen with zeros before signed math.
  assign rs = signed'(W'(r));
  assign gs = signed'(W'(g));
  assign bs = signed'(W'(b));

  assign y  = rs * KYR  + gs * KYG  + bs * KYB;
  assign cb = rs * KCBR + gs * KCBG + bs * KCBB + KOFF;
  assign cr = rs * KCRR + gs * KCRG + bs * KCRB + KOFF;

endmodule

// File: rtl/rgb2ycbcr_container.sv
// 8x8 block RGB to YCbCr converter time-multiplexing CORE_COUNT cores.
// Optional busy output is enabled by defining RGB2YCBCR_BUSY_EN.
module rgb2ycbcr_container
  import rgb2ycbcr_pkg::*;
#(
  parameter int fixed_point_length = 32,
  parameter int input_width        = 8,
  parameter int PIXEL_COUNT        = 64,
  parameter int CORE_COUNT         = 8
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     start,
  input  logic [input_width*PIXEL_COUNT-1:0]        r_all,
  input  logic [input_width*PIXEL_COUNT-1:0]        g_all,
  input  logic [input_width*PIXEL_COUNT-1:0]        b_all,
  output logic [fixed_point_length*PIXEL_COUNT-1:0] y_all,
  output logic [fixed_point_length*PIXEL_COUNT-1:0] cb_all,
  output logic [fixed_point_length*PIXEL_COUNT-1:0] cr_all,
  output logic                                     done
`ifdef RGB2YCBCR_BUSY_EN
  ,
  output logic                                     busy
`endif
);

  localparam int FPL     = fixed_point_length;
  localparam int IW      = input_width;
  localparam int BATCHES = PIXEL_COUNT / CORE_COUNT;
  localparam int BW      = (BATCHES > 1) ? $clog2(BATCHES) : 1;

  state_t            state_q;
  state_t            state_d;
  logic [BW-1:0]     batch_q;
  logic              last;

  logic [IW*PIXEL_COUNT-1:0] r_cap;
  logic [IW*PIXEL_COUNT-1:0] g_cap;
  logic [IW*PIXEL_COUNT-1:0] b_cap;

  logic signed [FPL-1:0] y_core  [CORE_COUNT];
  logic signed [FPL-1:0] cb_core [CORE_COUNT];
  logic signed [FPL-1:0] cr_core [CORE_COUNT];

  assign last = (batch_q == BW'(BATCHES - 1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    if (!start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  assign done = (state_q == DONE);
`ifdef RGB2YCBCR_BUSY_EN
  assign busy = (state_q == RUN);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cap   <= '0;
      g_cap   <= '0;
      b_cap   <= '0;
      batch_q <= '0;
    end else if (state_q == IDLE && start) begin
      r_cap   <= r_all;
      g_cap   <= g_all;
      b_cap   <= b_all;
      batch_q <= '0;
    end else if (state_q == RUN) begin
      batch_q <= batch_q + 1'b1;
    end
  end

  for (genvar j = 0; j < CORE_COUNT; j++) begin : g_core
    logic [IW-1:0] r_px;
    logic [IW-1:0] g_px;
    logic [IW-1:0] b_px;

    // Core j always serves the j-th pixel of the current batch.
    assign r_px = r_cap[(int'(batch_q) * CORE_COUNT + j) * IW +: IW];
    assign g_px = g_cap[(int'(batch_q) * CORE_COUNT + j) * IW +: IW];
    assign b_px = b_cap[(int'(batch_q) * CORE_COUNT + j) * IW +: IW];

    rgb2ycbcr_core #(
      .fixed_point_length(FPL),
      .input_width       (IW)
    ) u_core (
      .r (r_px),
      .g (g_px),
      .b (b_px),
      .y (y_core[j]),
      .cb(cb_core[j]),
      .cr(cr_core[j])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      y_all  <= '0;
      cb_all <= '0;
      cr_all <= '0;
    end else if (state_q == RUN) begin
      for (int j = 0; j < CORE_COUNT; j++) begin
        y_all[(int'(batch_q) * CORE_COUNT + j) * FPL +: FPL]  <= y_core[j];
        cb_all[(int'(batch_q) * CORE_COUNT + j) * FPL +: FPL] <= cb_core[j];
        cr_all[(int'(batch_q) * CORE_COUNT + j) * FPL +: FPL] <= cr_core[j];
      end
    end
  end

endmodule

// File: tb/tb_rgb2ycbcr_container.sv
// Directed and model-checked bench for the block RGB to YCbCr converter.
// Uniform blocks use hand-computed words; random blocks use a float model.
module tb_rgb2ycbcr_container;

  localparam int FPL = 32;
  localparam int IW  = 8;
  localparam int PC  = 64;
  localparam int CC  = 8;
  localparam int NB  = PC / CC;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [IW*PC-1:0]  r_all;
  logic [IW*PC-1:0]  g_all;
  logic [IW*PC-1:0]  b_all;
  logic [FPL*PC-1:0] y_all;
  logic [FPL*PC-1:0] cb_all;
  logic [FPL*PC-1:0] cr_all;
  logic              done;

  always #5 clk = ~clk;

  rgb2ycbcr_container #(
    .fixed_point_length(FPL),
    .input_width       (IW),
    .PIXEL_COUNT       (PC),
    .CORE_COUNT        (CC)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .r_all (r_all),
    .g_all (g_all),
    .b_all (b_all),
    .y_all (y_all),
    .cb_all(cb_all),
    .cr_all(cr_all),
    .done  (done)
  );

  typedef struct {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    int         y;
    int         cb;
    int         cr;
  } vec_t;

  vec_t vt[5];

  int checks   = 0;
  int failures = 0;

  int         ey [PC];
  int         ecb[PC];
  int         ecr[PC];
  logic [7:0] pr [PC];
  logic [7:0] pg [PC];
  logic [7:0] pb [PC];

  task automatic chk(input string name, input int act, input int exp,
                     input int tol);
    checks++;
    if (act - exp > tol || exp - act > tol) begin
      failures++;
      $display("FAIL %s actual=%h required=%h tol=%h", name, act, exp, tol);
    end
  endtask

  task automatic drive_pixels();
    for (int i = 0; i < PC; i++) begin
      r_all[i*IW +: IW] = pr[i];
      g_all[i*IW +: IW] = pg[i];
      b_all[i*IW +: IW] = pb[i];
    end
  endtask

  task automatic set_uniform(input vec_t v);
    for (int i = 0; i < PC; i++) begin
      pr[i]  = v.r;
      pg[i]  = v.g;
      pb[i]  = v.b;
      ey[i]  = v.y;
      ecb[i] = v.cb;
      ecr[i] = v.cr;
    end
  endtask

  task automatic set_random_model();
    real rr, gg, bb;
    for (int i = 0; i < PC; i++) begin
      pr[i] = 8'($urandom_range(0, 255));
      pg[i] = 8'($urandom_range(0, 255));
      pb[i] = 8'($urandom_range(0, 255));
      rr = pr[i];
      gg = pg[i];
      bb = pb[i];
      ey[i]  = $rtoi((0.299 * rr + 0.587 * gg + 0.114 * bb) * 65536.0 + 0.5);
      ecb[i] = $rtoi((-0.168736 * rr - 0.331264 * gg + 0.5 * bb + 128.0)
                     * 65536.0 + 0.5);
      ecr[i] = $rtoi((0.5 * rr - 0.418688 * gg - 0.081312 * bb + 128.0)
                     * 65536.0 + 0.5);
    end
  endtask

  task automatic set_zero_exp();
    for (int i = 0; i < PC; i++) begin
      ey[i]  = 0;
      ecb[i] = 0;
      ecr[i] = 0;
    end
  endtask

  task automatic check_outputs(input string tag, input int tol);
    for (int i = 0; i < PC; i++) begin
      chk($sformatf("%s y[%0d]", tag, i), int'(y_all[i*FPL +: FPL]),
          ey[i], tol);
      chk($sformatf("%s cb[%0d]", tag, i), int'(cb_all[i*FPL +: FPL]),
          ecb[i], tol);
      chk($sformatf("%s cr[%0d]", tag, i), int'(cr_all[i*FPL +: FPL]),
          ecr[i], tol);
    end
  endtask

  // Raise start, capture at the next edge, measure edges until done.
  task automatic run_block(input string tag);
    int lat;
    @(negedge clk);
    drive_pixels();
    start = 1'b1;
    @(posedge clk);
    #1;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        break;
      end
    end
    chk({tag, " latency"}, lat, NB, 0);
  endtask

  task automatic drop_start(input string tag);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, " done clears"}, int'(done), 0, 0);
  endtask

  initial begin
    vt[0] = '{8'd0,   8'd0,   8'd0,   32'h0000_0000, 32'h0080_0000,
              32'h0080_0000};
    vt[1] = '{8'd255, 8'd255, 8'd255, 32'h00FF_0000, 32'h007F_FF01,
              32'h0080_0000};
    vt[2] = '{8'd255, 8'd0,   8'd0,   32'h004C_3E75, 32'h0054_F833,
              32'h00FF_8000};
    vt[3] = '{8'd0,   8'd255, 8'd0,   32'h0095_AFBA, 32'h002B_86CE,
              32'h0015_3C2F};
    vt[4] = '{8'd0,   8'd0,   8'd255, 32'h001D_11D1, 32'h00FF_8000,
              32'h006B_43D1};

    rst   = 1'b0;
    start = 1'b0;
    r_all = '0;
    g_all = '0;
    b_all = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset done", int'(done), 0, 0);
    set_zero_exp();
    check_outputs("reset", 0);
    @(negedge clk);
    rst = 1'b1;

    for (int k = 0; k < 5; k++) begin
      set_uniform(vt[k]);
      run_block($sformatf("vec%0d", k));
      check_outputs($sformatf("vec%0d", k), 0);
      drop_start($sformatf("vec%0d", k));
    end

    // Inputs changed mid-run must not leak into the results.
    set_random_model();
    @(negedge clk);
    drive_pixels();
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    r_all = ~r_all;
    g_all = ~g_all;
    b_all = ~b_all;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (done) break;
    end
    chk("alter done", int'(done), 1, 0);
    check_outputs("alter", 32'h8000);

    // Hold start in DONE with new inputs: no second conversion.
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("hold%0d done", c), int'(done), 1, 0);
    end
    check_outputs("hold", 32'h8000);
    drop_start("hold");
    check_outputs("retain", 32'h8000);
    repeat (3) @(posedge clk);
    #1;
    chk("idle stays", int'(done), 0, 0);

    // Asynchronous reset after batch 3 of a fresh conversion.
    set_random_model();
    @(negedge clk);
    drive_pixels();
    start = 1'b1;
    @(posedge clk);
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst done", int'(done), 0, 0);
    set_zero_exp();
    check_outputs("midrst", 0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    set_random_model();
    run_block("post");
    check_outputs("post", 32'h8000);
    drop_start("post");

    set_random_model();
    run_block("rand2");
    check_outputs("rand2", 32'h8000);
    drop_start("rand2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
